ch_advert_tx: RTL

// Transmit side of the cluster-head (CH) advertisement protocol. Builds 6-word CH advert packets

---
 rtl/ch_advert_tx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ch_advert_tx.sv
// Cluster-head advert transmitter: builds 6-word CH advert packets
// from a self request or a hop-incremented relay request.
module ch_advert_tx #(
  parameter int WORD_WIDTH = 16,
  parameter logic [WORD_WIDTH-1:0] PKT_TYPE_CH = 16'h0002
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HB_reset,
  input  logic [WORD_WIDTH-1:0] HB_CHlimit,
  input  logic [WORD_WIDTH-1:0] own_ID,
  input  logic                  en_self,
  input  logic [WORD_WIDTH-1:0] self_QValue,
  input  logic                  en_relay,
  input  logic [WORD_WIDTH-1:0] rCH_ID,
  input  logic [WORD_WIDTH-1:0] rCH_Hops,
  input  logic [WORD_WIDTH-1:0] rCH_QValue,
  output logic [WORD_WIDTH-1:0] tx_word,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  relay_drop
);

  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t     state;
  logic       src;
  logic [2:0] idx;

  logic  self_pend;
  word_t self_q;
  logic  relay_pend;
  word_t relay_id;
  word_t relay_hops;
  word_t relay_q;

  word_t sh_own;
  word_t sh_id;
  word_t sh_hops;
  word_t sh_q;
  word_t sh_ck;

  word_t nh;
  logic  hop_bad;
  word_t ld_id;
  word_t ld_hops;
  word_t ld_q;
  word_t nxt_word;

  // An all-ones hop count would wrap, so it is rejected outright.
  assign nh      = rCH_Hops + WORD_WIDTH'(1);
  assign hop_bad = (&rCH_Hops) || (nh > HB_CHlimit);

  assign ld_id   = src ? relay_id   : own_ID;
  assign ld_hops = src ? relay_hops : '0;
  assign ld_q    = src ? relay_q    : self_q;

  assign tx_busy = (state != S_IDLE);

  // Word following the one currently presented.
  always_comb begin
    nxt_word = sh_ck;
    case (idx)
      3'd0:    nxt_word = sh_own;
      3'd1:    nxt_word = sh_id;
      3'd2:    nxt_word = sh_hops;
      3'd3:    nxt_word = sh_q;
      default: nxt_word = sh_ck;
    endcase
  end

  // Packet FSM plus request capture; capture runs after the
  // load-time clear so a request in the load cycle is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      src        <= 1'b0;
      idx        <= '0;
      self_pend  <= 1'b0;
      self_q     <= '0;
      relay_pend <= 1'b0;
      relay_id   <= '0;
      relay_hops <= '0;
      relay_q    <= '0;
      sh_own     <= '0;
      sh_id      <= '0;
      sh_hops    <= '0;
      sh_q       <= '0;
      sh_ck      <= '0;
      tx_word    <= '0;
      tx_valid   <= 1'b0;
      tx_last    <= 1'b0;
      tx_done    <= 1'b0;
      relay_drop <= 1'b0;
    end else begin
      tx_done    <= 1'b0;
      relay_drop <= 1'b0;
      case (state)
        S_IDLE: begin
          if (self_pend) begin
            src   <= 1'b0;
            state <= S_LOAD;
          end else if (relay_pend) begin
            src   <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          sh_own  <= own_ID;
          sh_id   <= ld_id;
          sh_hops <= ld_hops;
          sh_q    <= ld_q;
          sh_ck   <= PKT_TYPE_CH ^ own_ID ^ ld_id
                     ^ ld_hops ^ ld_q;
          if (src) relay_pend <= 1'b0;
          else     self_pend  <= 1'b0;
          idx      <= '0;
          tx_word  <= PKT_TYPE_CH;
          tx_valid <= 1'b1;
          tx_last  <= 1'b0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            if (idx == 3'd5) begin
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              tx_done  <= 1'b1;
              state    <= S_DONE;
            end else begin
              idx     <= idx + 3'd1;
              tx_word <= nxt_word;
              tx_last <= (idx == 3'd4);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (HB_reset) begin
        self_pend  <= 1'b0;
        relay_pend <= 1'b0;
      end else begin
        if (en_self) begin
          self_pend <= 1'b1;
          self_q    <= self_QValue;
        end
        if (en_relay) begin
          if (hop_bad) begin
            relay_drop <= 1'b1;
          end else begin
            relay_pend <= 1'b1;
            relay_id   <= rCH_ID;
            relay_hops <= nh;
            relay_q    <= rCH_QValue;
          end
        end
      end
    end
  end

endmodule
